// File: rtl/wb_stage.sv
// RV32I write-back stage: retires instructions into the register-file write port,
// aligning and extending load data. Optional macro WB_INSTRET_EN adds o_instret.
`timescale 1ns/1ps
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_rd_wr_en,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_is_load,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_result,
  input  logic            i_ld_valid,
  input  logic [XLEN-1:0] i_ld_data,
  output logic            o_ld_ready,
  output logic            o_rd_wr,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     o_instret
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_LD, WRITE} state_t;

  state_t      state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic        rd_wr_q, rd_wr_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [63:0] instret_q, instret_d;
  logic        accept;

  function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] sh_b, sh_h;
    sh_b = w >> {lo, 3'b000};
    sh_h = w >> {lo[1], 4'b0000};
    case (f3)
      3'b000:  align_load = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  align_load = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b100:  align_load = {24'd0, sh_b[7:0]};
      3'b101:  align_load = {16'd0, sh_h[15:0]};
      default: align_load = w;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    rd_wr_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    instret_d = (state_q == WRITE) ? instret_q + 64'd1 : instret_q;
    accept    = i_valid && (state_q != WAIT_LD);
    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          wr_en_d = i_rd_wr_en;
          addr_d  = i_rd_addr;
          f3_d    = i_funct3;
          lo_d    = i_addr_lo;
          if (i_is_load) begin
            state_d = WAIT_LD;
          end else begin
            // Non-loads go straight to the output registers so WRITE can retire next cycle.
            state_d   = WRITE;
            rd_wr_d   = i_rd_wr_en && (i_rd_addr != 5'd0);
            rd_addr_d = i_rd_addr;
            rd_data_d = i_result;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LD: begin
        if (i_ld_valid) begin
          state_d   = WRITE;
          rd_wr_d   = wr_en_q && (addr_q != 5'd0);
          rd_addr_d = addr_q;
          rd_data_d = align_load(f3_q, lo_q, i_ld_data);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      addr_q    <= 5'd0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      rd_wr_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      rd_wr_q   <= rd_wr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      instret_q <= instret_d;
    end
  end

  assign o_ready    = (state_q == IDLE) || (state_q == WRITE);
  assign o_ld_ready = (state_q == WAIT_LD);
  assign o_rd_wr    = rd_wr_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;
`ifdef WB_INSTRET_EN
  assign o_instret  = instret_q;
`else
  logic unused_instret;
  assign unused_instret = ^instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized retirements
// checked against a transaction-level model of the write port.
`timescale 1ns/1ps
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_rd_wr_en = 1'b0, i_is_load = 1'b0, i_ld_valid = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [2:0]  i_funct3 = '0;
  logic [1:0]  i_addr_lo = '0;
  logic [31:0] i_result = '0, i_ld_data = '0;
  logic        o_ready, o_ld_ready, o_rd_wr;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
`ifdef WB_INSTRET_EN
  logic [63:0] o_instret;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  longint unsigned exp_ir = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_rd_wr_en(i_rd_wr_en), .i_rd_addr(i_rd_addr), .i_is_load(i_is_load),
    .i_funct3(i_funct3), .i_addr_lo(i_addr_lo), .i_result(i_result),
    .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data), .o_ld_ready(o_ld_ready),
    .o_rd_wr(o_rd_wr), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data)
`ifdef WB_INSTRET_EN
    , .o_instret(o_instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * lo)) % 256;
    h = (w >> (16 * (lo / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic expect_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    check("wr_strobe", o_rd_wr, (we && a != 0));
    check("wr_addr", o_rd_addr, a);
    check("wr_data", o_rd_data, d);
    check("wr_ready", o_ready, 1'b1);
    check("wr_ld_ready", o_ld_ready, 1'b0);
`ifdef WB_INSTRET_EN
    check("instret", o_instret, exp_ir);
`endif
    exp_ir++;
    last_addr = a;
    last_data = d;
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_strobe"}, o_rd_wr, 1'b0);
    check({tag, "_addr_hold"}, o_rd_addr, last_addr);
    check({tag, "_data_hold"}, o_rd_data, last_data);
  endtask

  task automatic issue(input logic ld, input logic we, input logic [4:0] a, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] res);
    check("issue_ready", o_ready, 1'b1);
    i_valid = 1'b1; i_is_load = ld; i_rd_wr_en = we; i_rd_addr = a;
    i_funct3 = f3; i_addr_lo = lo; i_result = res;
  endtask

  task automatic nonload(input logic we, input logic [4:0] a, input logic [31:0] res,
                         input bit hold);
    issue(1'b0, we, a, 3'($urandom), 2'($urandom), res);
    tick();
    if (!hold) i_valid = 1'b0;
    expect_write(we, a, res);
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] lo, input logic we,
                      input logic [4:0] a, input logic [31:0] w, input int dly);
    issue(1'b1, we, a, f3, lo, $urandom);
    tick();
    i_valid = 1'b0;
    check("wait_ready", o_ready, 1'b0);
    check("wait_ld_ready", o_ld_ready, 1'b1);
    expect_quiet("wait");
    for (int k = 0; k < dly; k++) begin
      i_ld_data = $urandom;
      tick();
      check("wait_ready", o_ready, 1'b0);
      check("wait_ld_ready", o_ld_ready, 1'b1);
      expect_quiet("wait");
    end
    i_ld_valid = 1'b1; i_ld_data = w;
    tick();
    i_ld_valid = 1'b0; i_ld_data = $urandom;
    expect_write(we, a, model_load(f3, lo, w));
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    #1 rst = 1'b0;
    #2;
    check("rst_rd_wr", o_rd_wr, 1'b0);
    check("rst_rd_addr", o_rd_addr, 5'd0);
    check("rst_rd_data", o_rd_data, 32'd0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_ld_ready", o_ld_ready, 1'b0);
`ifdef WB_INSTRET_EN
    check("rst_instret", o_instret, 64'd0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Single non-load, one-cycle strobe
    nonload(1'b1, 5'd5, 32'h1234_5678, 1'b0);
    tick();
    expect_quiet("single_after");

    // Back-to-back non-loads to x1..x4
    for (int r = 1; r <= 4; r++) nonload(1'b1, 5'(r), 32'hA000_0000 + r, (r != 4));
    tick();
    expect_quiet("b2b_after");

    // Load alignment cases
    load(3'd0, 2'd3, 1'b1, 5'd10, 32'h80AA_BBCC, 3);
    check("lb_value", o_rd_data, 32'hFFFF_FF80);
    load(3'd4, 2'd3, 1'b1, 5'd11, 32'h80AA_BBCC, 3);
    check("lbu_value", o_rd_data, 32'h0000_0080);
    load(3'd1, 2'd2, 1'b1, 5'd12, 32'h80AA_BBCC, 0);
    check("lh_value", o_rd_data, 32'hFFFF_80AA);
    i_valid = 1'b0;
    tick();
    expect_quiet("load_after");

    // Write to x0 is suppressed but still retires
    nonload(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
    tick();
    expect_quiet("x0_after");
`ifdef WB_INSTRET_EN
    check("x0_instret", o_instret, exp_ir);
`endif

    // Stray load data while idle is ignored
    i_ld_valid = 1'b1; i_ld_data = 32'hFFFF_FFFF;
    tick();
    i_ld_valid = 1'b0;
    check("stray_ld_ready", o_ld_ready, 1'b0);
    check("stray_ready", o_ready, 1'b1);
    expect_quiet("stray");
    load(3'd2, 2'd0, 1'b1, 5'd20, 32'h0BAD_F00D, 1);
    i_valid = 1'b0;
    tick();

    // Reset while waiting for load data
    issue(1'b1, 1'b1, 5'd7, 3'd2, 2'd0, 32'd0);
    tick();
    i_valid = 1'b0;
    check("prerst_ld_ready", o_ld_ready, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_rd_wr", o_rd_wr, 1'b0);
    check("midrst_ready", o_ready, 1'b1);
    check("midrst_ld_ready", o_ld_ready, 1'b0);
    check("midrst_rd_addr", o_rd_addr, 5'd0);
    check("midrst_rd_data", o_rd_data, 32'd0);
    last_addr = '0; last_data = '0; exp_ir = 0;
    i_ld_valid = 1'b1; i_ld_data = 32'h5555_AAAA;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("postrst_ld_ready", o_ld_ready, 1'b0);
      expect_quiet("postrst");
    end
    i_ld_valid = 1'b0;
`ifdef WB_INSTRET_EN
    check("postrst_instret", o_instret, 64'd0);
`endif

    // Randomized retirement stream
    for (int n = 0; n < 60; n++) begin
      logic [4:0]  a;
      logic        we;
      a  = 5'($urandom);
      we = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        nonload(we, a, $urandom, 1'b0);
      else
        load(f3_tab[$urandom_range(0, 7)], 2'($urandom), we, a, $urandom, $urandom_range(0, 3));
      i_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        tick();
        expect_quiet("rand_idle");
      end
    end
    tick();
    expect_quiet("final");
`ifdef WB_INSTRET_EN
    check("final_instret", o_instret, exp_ir);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
